// File: rtl/instr_loader_if.sv
// ============================================================================
// Module   : instr_loader_if
// Purpose  : Stream-in / instruction-memory-out bundle for the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_loader_if;
  logic        load_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, done, error, words_loaded
  );

  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, done, error, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module   : instr_loader
// Purpose  : Loads a length/payload/checksum word stream into instruction
//            memory while holding the CPU; releases it on a checksum match.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic           clk,
  input  logic           pc_reset,
  instr_loader_if.slave  bus
);

  localparam logic [16:0] c_DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_len;
  logic [15:0] r_count;
  logic [15:0] r_sum;
  logic        r_we;
  logic [15:0] r_waddr;
  logic [15:0] r_wdata;

  logic        w_ready;
  logic        w_clear;
  logic        w_hdr;
  logic        w_pay;
  logic        w_hold;
  logic        w_done;
  logic        w_err;
  logic        w_len_bad;

  assign w_len_bad = (bus.in_data == 16'd0) || ({1'b0, bus.in_data} > c_DEPTH);

  always_ff @(posedge clk) begin
    if (pc_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_clear = 1'b0;
    w_hdr   = 1'b0;
    w_pay   = 1'b0;
    w_hold  = 1'b1;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        w_hold = (r_state != S_DONE);
        w_done = (r_state == S_DONE);
        w_err  = (r_state == S_ERROR);
        if (bus.load_start) begin
          w_next  = S_HEADER;
          w_clear = 1'b1;
        end
      end
      S_HEADER: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_hdr  = 1'b1;
          w_next = w_len_bad ? S_ERROR : S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_pay = 1'b1;
          if (r_count + 16'd1 == r_len) begin
            w_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = (bus.in_data == r_sum) ? S_DONE : S_ERROR;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Write port is registered so imem sees each payload word one cycle after it is accepted.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      r_len   <= 16'd0;
      r_count <= 16'd0;
      r_sum   <= 16'd0;
      r_we    <= 1'b0;
      r_waddr <= 16'd0;
      r_wdata <= 16'd0;
    end else begin
      r_we <= w_pay;
      if (w_clear) begin
        r_count <= 16'd0;
        r_sum   <= 16'd0;
      end
      if (w_hdr) begin
        r_len <= bus.in_data;
      end
      if (w_pay) begin
        r_count <= r_count + 16'd1;
        r_sum   <= r_sum + bus.in_data;
        r_waddr <= BASE_ADDR + r_count;
        r_wdata <= bus.in_data;
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_waddr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_hold     = w_hold;
  assign bus.done         = w_done;
  assign bus.error        = w_err;
  assign bus.words_loaded = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Randomized stream stimulus against a stream-position model of the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_loader;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [15:0] BASE   = 16'h0000;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic pc_reset;
  instr_loader_if bus();

  instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .pc_reset (pc_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model tracks the position inside the current stream: 0 = header, 1..N payload, N+1 checksum.
  bit          m_known  = 1'b0;
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  int          m_n      = 0;
  int          m_count  = 0;
  int          m_result = 0;
  logic [15:0] m_sum    = 16'd0;
  bit          m_we     = 1'b0;
  logic [15:0] m_addr   = 16'd0;
  logic [15:0] m_data   = 16'd0;

  int          wr_cnt = 0;
  logic [15:0] mem [0:DEPTH-1];

  always @(negedge clk) begin
    logic [15:0] w;
    if (m_known) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_active));
      chk("imem_we", 32'(bus.imem_we), 32'(m_we));
      if (m_we) begin
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
        chk("imem_wdata", 32'(bus.imem_wdata), 32'(m_data));
      end
      chk("cpu_hold", 32'(bus.cpu_hold), 32'(!(!m_active && m_result == 1)));
      chk("done", 32'(bus.done), 32'(!m_active && m_result == 1));
      chk("error", 32'(bus.error), 32'(!m_active && m_result == 2));
      chk("words_loaded", 32'(bus.words_loaded), 32'(m_count));
    end
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      mem[bus.imem_addr[ADDR_W-1:0]] = bus.imem_wdata;
    end
    m_we = 1'b0;
    w    = bus.in_data;
    if (pc_reset) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_result = 0;
      m_count  = 0;
      m_sum    = 16'd0;
    end else if (!m_active) begin
      if (bus.load_start) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_sum    = 16'd0;
        m_count  = 0;
        m_result = 0;
      end
    end else if (bus.in_valid) begin
      if (m_pos == 0) begin
        m_n = int'(w);
        if (m_n == 0 || m_n > DEPTH) begin
          m_active = 1'b0;
          m_result = 2;
        end else begin
          m_pos = 1;
        end
      end else if (m_pos <= m_n) begin
        m_we    = 1'b1;
        m_addr  = BASE + 16'(m_pos - 1);
        m_data  = w;
        m_sum   = m_sum + w;
        m_count = m_count + 1;
        m_pos   = m_pos + 1;
      end else begin
        m_active = 1'b0;
        m_result = (w == m_sum) ? 1 : 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int stall, input bit poke);
    int g;
    for (int i = 0; i < stall; i++) begin
      idle_in();
      tick();
    end
    bus.in_valid   = 1'b1;
    bus.in_data    = w;
    bus.load_start = poke;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    chk("handshake_wait", 32'(g < 40), 32'd1);
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_all(input wq_t q, input int stall_max, input bit pokes);
    for (int i = 0; i < q.size(); i++) begin
      send(q[i], $urandom_range(stall_max, 0),
           pokes && i > 0 && i < q.size() - 1 && ($urandom_range(3, 0) == 0));
    end
    idle_in();
    repeat (3) tick();
  endtask

  task automatic run_load(input wq_t q, input int stall_max, input bit pokes);
    start();
    send_all(q, stall_max, pokes);
  endtask

  function automatic wq_t make_stream(input int n, input bit corrupt);
    wq_t         q;
    logic [15:0] s;
    logic [15:0] v;
    s = 16'd0;
    q.push_back(16'(n));
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom);
      s = s + v;
      q.push_back(v);
    end
    q.push_back(corrupt ? s + 16'($urandom_range(65535, 1)) : s);
    return q;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
    chk({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t q;
    int  w0;
    int  n;
    bit  good;
    bit  corrupt;
    bit  exp_ok;

    bus.load_start = 1'b0;
    idle_in();
    pc_reset = 1'b1;
    repeat (2) tick();
    chk_reset_vals("reset");
    pc_reset = 1'b0;
    tick();

    // Normal load
    w0 = wr_cnt;
    q = '{16'd3, 16'h1001, 16'h2002, 16'h3003, 16'h6006};
    run_load(q, 0, 1'b0);
    chk("norm_writes", 32'(wr_cnt - w0), 32'd3);
    chk("norm_mem0", 32'(mem[0]), 32'h1001);
    chk("norm_mem1", 32'(mem[1]), 32'h2002);
    chk("norm_mem2", 32'(mem[2]), 32'h3003);
    chk("norm_done", 32'(bus.done), 32'd1);
    chk("norm_hold", 32'(bus.cpu_hold), 32'd0);
    chk("norm_words", 32'(bus.words_loaded), 32'd3);
    chk("norm_model_sum", 32'(m_sum), 32'h6006);

    // Restart from DONE with a bad checksum
    w0 = wr_cnt;
    start();
    chk("restart_hold", 32'(bus.cpu_hold), 32'd1);
    chk("restart_words", 32'(bus.words_loaded), 32'd0);
    q = '{16'd3, 16'h1001, 16'h2002, 16'h3003, 16'h6007};
    send_all(q, 0, 1'b0);
    chk("badsum_writes", 32'(wr_cnt - w0), 32'd3);
    chk("badsum_mem0", 32'(mem[0]), 32'h1001);
    chk("badsum_error", 32'(bus.error), 32'd1);
    chk("badsum_done", 32'(bus.done), 32'd0);
    chk("badsum_hold", 32'(bus.cpu_hold), 32'd1);

    // Length boundaries
    w0 = wr_cnt;
    q = '{16'd0};
    run_load(q, 0, 1'b0);
    chk("len0_error", 32'(bus.error), 32'd1);
    q = '{16'd257};
    run_load(q, 0, 1'b0);
    chk("len257_error", 32'(bus.error), 32'd1);
    chk("badlen_writes", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt;
    run_load(make_stream(256, 1'b0), 0, 1'b0);
    chk("len256_done", 32'(bus.done), 32'd1);
    chk("len256_words", 32'(bus.words_loaded), 32'd256);
    chk("len256_writes", 32'(wr_cnt - w0), 32'd256);

    // Stalls every other cycle and checksum wrap-around
    w0 = wr_cnt;
    q = '{16'd2, 16'hFFFF, 16'h0002, 16'h0001};
    start();
    for (int i = 0; i < 4; i++) send(q[i], 1, 1'b0);
    idle_in();
    repeat (3) tick();
    chk("wrap_model_sum", 32'(m_sum), 32'h0001);
    chk("wrap_done", 32'(bus.done), 32'd1);
    chk("wrap_writes", 32'(wr_cnt - w0), 32'd2);
    chk("wrap_mem0", 32'(mem[0]), 32'hFFFF);
    chk("wrap_mem1", 32'(mem[1]), 32'h0002);

    // Reset after two of five payload words
    q = make_stream(5, 1'b0);
    start();
    for (int i = 0; i < 3; i++) send(q[i], 0, 1'b0);
    bus.in_valid   = 1'b1;
    bus.in_data    = q[3];
    bus.load_start = 1'b1;
    pc_reset       = 1'b1;
    tick();
    chk_reset_vals("midreset");
    pc_reset       = 1'b0;
    bus.load_start = 1'b0;
    idle_in();
    w0 = wr_cnt;
    repeat (5) tick();
    chk("midreset_no_writes", 32'(wr_cnt - w0), 32'd0);
    run_load(make_stream(5, 1'b0), 1, 1'b0);
    chk("after_reset_done", 32'(bus.done), 32'd1);
    chk("after_reset_words", 32'(bus.words_loaded), 32'd5);

    // Randomized loads with stalls, ignored load_start pulses and faults
    for (int t = 0; t < 12; t++) begin
      w0 = wr_cnt;
      if ($urandom_range(5, 0) == 0) begin
        good = 1'b0;
        n = ($urandom_range(1, 0) == 0) ? 0 : DEPTH + 1 + int'($urandom_range(300, 0));
        q = '{16'(n)};
        exp_ok = 1'b0;
      end else begin
        good    = 1'b1;
        n       = $urandom_range(12, 1);
        corrupt = ($urandom_range(3, 0) == 0);
        q       = make_stream(n, corrupt);
        exp_ok  = !corrupt;
      end
      run_load(q, 2, 1'b1);
      chk("rand_done", 32'(bus.done), 32'(exp_ok));
      chk("rand_error", 32'(bus.error), 32'(!exp_ok));
      chk("rand_writes", 32'(wr_cnt - w0), good ? 32'(n) : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
